cv32e40s_mpu_req_arbiter: RTL and testbench
===========================================

CV32E40S_MPU_REQ_ARBITER -- requirements
Module: cv32e40s_mpu_req_arbiter

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 2, meaning maximum accepted-but-unresponded transactions; legal values 1..4.
REQ-002 SHALL have port clk, input, 1, the single clock.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports r0_valid_i input 1 and r0_ready_o output 1: the core LSU request handshake.
REQ-005 SHALL have ports r0_addr_i input 32, r0_we_i input 1, r0_be_i input 4, r0_wdata_i input 32: the core LSU request fields.
REQ-006 SHALL have port r0_lock_i, input, 1: high means the current r0 request is the first half of a misaligned pair.
REQ-007 SHALL have ports r1_valid_i, r1_ready_o, r1_addr_i, r1_we_i, r1_be_i, r1_wdata_i: the XIF request, with widths as for r0.
REQ-008 SHALL have ports mpu_trans_valid_o output 1 and mpu_trans_ready_i input 1: the MPU request handshake.
REQ-009 SHALL have ports mpu_addr_o 32, mpu_we_o 1, mpu_be_o 4, mpu_wdata_o 32: outputs muxed from the granted requester.
REQ-010 SHALL have port mpu_err_wait_o, output, 1: high when r0 is granted, low when r1 is granted.
REQ-011 SHALL have port one_txn_pend_n_o, output, 1: next-cycle outstanding count equals 1.
REQ-012 SHALL have ports mpu_resp_valid_i input 1, mpu_resp_rdata_i input 32, mpu_resp_status_i input 2 (0=OK, 1=read fault, 2=write fault).
REQ-013 SHALL have ports r0_resp_valid_o, r1_resp_valid_o (output 1 each) and resp_rdata_o 32, resp_status_o 2, the latter two shared by both requesters.

Function
REQ-014 SHALL implement grant state GNT_R0/GNT_R1 in a register, with grant_q reset to GNT_R0.
REQ-015 SHALL hold grant_q while mpu_trans_valid_o=1 and mpu_trans_ready_i=0: request fields stay stable until accepted.
REQ-016 SHALL hold grant_q at GNT_R0 after an accepted r0 request with r0_lock_i=1, until the next r0 acceptance with r0_lock_i=0.
REQ-017 SHALL otherwise arbitrate round-robin: if both are valid, grant the requester not granted at the last acceptance; if only one is valid, grant it.
REQ-018 SHALL drive mpu_trans_valid_o = granted requester's valid AND NOT full, where full = (count == MAX_OUTSTANDING).
REQ-019 SHALL drive r0_ready_o/r1_ready_o = mpu_trans_ready_i AND granted AND NOT full, and drive the non-granted ready at 0.
REQ-020 SHALL treat an acceptance as a cycle with mpu_trans_valid_o AND mpu_trans_ready_i, and push the granted ID into an in-order ID FIFO of depth MAX_OUTSTANDING.
REQ-021 SHALL treat a response as a cycle with mpu_resp_valid_i high, pop the FIFO head, and assert r<head>_resp_valid_o combinationally in the same cycle.
REQ-022 SHALL pass resp_rdata_o and resp_status_o through from the mpu_resp inputs unregistered.
REQ-023 SHALL keep count, with count_n = count + accept - response; simultaneous accept and response leaves count unchanged and the FIFO rotates correctly.
REQ-024 SHALL block acceptance when full even if a response arrives in the same cycle (no same-cycle bypass).
REQ-025 SHALL drive one_txn_pend_n_o = (count_n == 1), combinationally.
REQ-026 SHALL ignore mpu_resp_valid_i when count==0: no pointer change, no r*_resp_valid_o.
REQ-027 SHALL wrap FIFO pointers modulo MAX_OUTSTANDING.
REQ-028 SHALL have zero-cycle request latency, a purely combinational path from request to MPU.

Reset
REQ-029 SHALL on rst_n=0, at any time including mid-transaction, clear count, FIFO pointers and lock, and set grant_q=GNT_R0.
REQ-030 SHALL hold all outputs at 0 during reset, except those driven combinationally from inputs (mpu_addr_o etc. follow r0 fields), and except mpu_err_wait_o, which is 1.

Verification
REQ-031 SHALL cover: r0 and r1 valid every cycle, ready=1, responses 1 cycle later -> grants alternate r0,r1,r0,r1; responses routed in the same order.
REQ-032 SHALL cover: r0 lock=1 then lock=0 with r1 valid throughout -> both r0 halves accepted consecutively before r1; mpu_err_wait_o=1 for both.
REQ-033 SHALL cover: MAX_OUTSTANDING=2, two accepts with no response -> r*_ready_o=0 and mpu_trans_valid_o=0; a response in the same cycle as a third request still blocks that request; accepted next cycle.
REQ-034 SHALL cover: count=1 with accept and response in the same cycle -> count stays 1 and one_txn_pend_n_o=1; count=0 with one accept -> one_txn_pend_n_o=1.
REQ-035 SHALL cover: mpu_trans_ready_i=0 for 3 cycles with r1 becoming valid -> grant stays r0 and fields stable until accepted.
REQ-036 SHALL cover: rst_n asserted with count=2 -> count=0 and grant_q=GNT_R0 immediately; a stray mpu_resp_valid_i after reset produces no r*_resp_valid_o.

Source files
------------

// File: rtl/cv32e40s_mpu_req_arbiter.sv
// Two-requester (LSU r0, XIF r1) round-robin arbiter in front of the MPU.
// Tracks outstanding transactions in an in-order ID FIFO to route responses back.
module cv32e40s_mpu_req_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        r0_valid_i,
    output logic        r0_ready_o,
    input  logic [31:0] r0_addr_i,
    input  logic        r0_we_i,
    input  logic [3:0]  r0_be_i,
    input  logic [31:0] r0_wdata_i,
    input  logic        r0_lock_i,

    input  logic        r1_valid_i,
    output logic        r1_ready_o,
    input  logic [31:0] r1_addr_i,
    input  logic        r1_we_i,
    input  logic [3:0]  r1_be_i,
    input  logic [31:0] r1_wdata_i,

    output logic        mpu_trans_valid_o,
    input  logic        mpu_trans_ready_i,
    output logic [31:0] mpu_addr_o,
    output logic        mpu_we_o,
    output logic [3:0]  mpu_be_o,
    output logic [31:0] mpu_wdata_o,
    output logic        mpu_err_wait_o,
    output logic        one_txn_pend_n_o,

    input  logic        mpu_resp_valid_i,
    input  logic [31:0] mpu_resp_rdata_i,
    input  logic [1:0]  mpu_resp_status_i,

    output logic        r0_resp_valid_o,
    output logic        r1_resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic [1:0]  resp_status_o
);

    localparam logic [0:0] GNT_R0 = 1'b0;
    localparam logic [0:0] GNT_R1 = 1'b1;

    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [0:0]       grant_q, grant_d;
    logic [0:0]       prio_q, prio_d;
    logic             lock_q, lock_d;
    logic             hold_q, hold_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [0:0]       id_q [MAX_OUTSTANDING];
    logic [0:0]       id_d [MAX_OUTSTANDING];

    logic [0:0]       gnt_c;
    logic             full_c;
    logic             gnt_valid_c;
    logic             accept_c;
    logic             resp_c;
    logic [0:0]       head_c;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Current grant: lock and stall-hold take precedence over round-robin.
    always_comb begin
        gnt_c = GNT_R0;
        if (!rst_n) begin
            gnt_c = GNT_R0;
        end else if (lock_q) begin
            gnt_c = GNT_R0;
        end else if (hold_q) begin
            gnt_c = grant_q;
        end else if (r0_valid_i && r1_valid_i) begin
            gnt_c = prio_q;
        end else if (r1_valid_i) begin
            gnt_c = GNT_R1;
        end
    end

    always_comb begin
        full_c      = (count_q == CNT_W'(MAX_OUTSTANDING));
        gnt_valid_c = (gnt_c == GNT_R1) ? r1_valid_i : r0_valid_i;

        mpu_trans_valid_o = rst_n & gnt_valid_c & ~full_c;
        r0_ready_o        = rst_n & mpu_trans_ready_i & (gnt_c == GNT_R0) & ~full_c;
        r1_ready_o        = rst_n & mpu_trans_ready_i & (gnt_c == GNT_R1) & ~full_c;
        mpu_err_wait_o    = (gnt_c == GNT_R0);

        mpu_addr_o  = (gnt_c == GNT_R1) ? r1_addr_i  : r0_addr_i;
        mpu_we_o    = (gnt_c == GNT_R1) ? r1_we_i    : r0_we_i;
        mpu_be_o    = (gnt_c == GNT_R1) ? r1_be_i    : r0_be_i;
        mpu_wdata_o = (gnt_c == GNT_R1) ? r1_wdata_i : r0_wdata_i;

        accept_c = mpu_trans_valid_o & mpu_trans_ready_i;
        resp_c   = rst_n & mpu_resp_valid_i & (count_q != '0);
        head_c   = id_q[rptr_q];

        r0_resp_valid_o = resp_c & (head_c == GNT_R0);
        r1_resp_valid_o = resp_c & (head_c == GNT_R1);
        resp_rdata_o    = mpu_resp_rdata_i;
        resp_status_o   = mpu_resp_status_i;
    end

    // Next-state for grant bookkeeping, count and ID FIFO.
    always_comb begin
        grant_d = gnt_c;
        prio_d  = prio_q;
        lock_d  = lock_q;
        hold_d  = mpu_trans_valid_o & ~mpu_trans_ready_i;
        count_d = count_q + CNT_W'(accept_c) - CNT_W'(resp_c);
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        id_d    = id_q;

        if (accept_c) begin
            prio_d         = ~gnt_c;
            wptr_d         = ptr_inc(wptr_q);
            id_d[wptr_q]   = gnt_c;
            if (gnt_c == GNT_R0) begin
                lock_d = r0_lock_i;
            end
        end
        if (resp_c) begin
            rptr_d = ptr_inc(rptr_q);
        end

        one_txn_pend_n_o = (count_d == CNT_W'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q <= GNT_R0;
            prio_q  <= GNT_R0;
            lock_q  <= 1'b0;
            hold_q  <= 1'b0;
            count_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
                id_q[i] <= GNT_R0;
            end
        end else begin
            grant_q <= grant_d;
            prio_q  <= prio_d;
            lock_q  <= lock_d;
            hold_q  <= hold_d;
            count_q <= count_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            id_q    <= id_d;
        end
    end

endmodule

// File: tb/tb_cv32e40s_mpu_req_arbiter.sv
// Bench for cv32e40s_mpu_req_arbiter: directed scenarios plus a short random run,
// checked every cycle against a queue-based model of the arbitration rules.
module tb_cv32e40s_mpu_req_arbiter;

    localparam int MAX = 2;

    logic        clk;
    logic        rst_n;
    logic        r0_valid_i, r0_ready_o, r0_we_i, r0_lock_i;
    logic [31:0] r0_addr_i, r0_wdata_i;
    logic [3:0]  r0_be_i;
    logic        r1_valid_i, r1_ready_o, r1_we_i;
    logic [31:0] r1_addr_i, r1_wdata_i;
    logic [3:0]  r1_be_i;
    logic        mpu_trans_valid_o, mpu_trans_ready_i;
    logic [31:0] mpu_addr_o, mpu_wdata_o;
    logic        mpu_we_o;
    logic [3:0]  mpu_be_o;
    logic        mpu_err_wait_o, one_txn_pend_n_o;
    logic        mpu_resp_valid_i;
    logic [31:0] mpu_resp_rdata_i;
    logic [1:0]  mpu_resp_status_i;
    logic        r0_resp_valid_o, r1_resp_valid_o;
    logic [31:0] resp_rdata_o;
    logic [1:0]  resp_status_o;

    cv32e40s_mpu_req_arbiter #(.MAX_OUTSTANDING(MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid_i(r0_valid_i), .r0_ready_o(r0_ready_o), .r0_addr_i(r0_addr_i),
        .r0_we_i(r0_we_i), .r0_be_i(r0_be_i), .r0_wdata_i(r0_wdata_i), .r0_lock_i(r0_lock_i),
        .r1_valid_i(r1_valid_i), .r1_ready_o(r1_ready_o), .r1_addr_i(r1_addr_i),
        .r1_we_i(r1_we_i), .r1_be_i(r1_be_i), .r1_wdata_i(r1_wdata_i),
        .mpu_trans_valid_o(mpu_trans_valid_o), .mpu_trans_ready_i(mpu_trans_ready_i),
        .mpu_addr_o(mpu_addr_o), .mpu_we_o(mpu_we_o), .mpu_be_o(mpu_be_o),
        .mpu_wdata_o(mpu_wdata_o), .mpu_err_wait_o(mpu_err_wait_o),
        .one_txn_pend_n_o(one_txn_pend_n_o),
        .mpu_resp_valid_i(mpu_resp_valid_i), .mpu_resp_rdata_i(mpu_resp_rdata_i),
        .mpu_resp_status_i(mpu_resp_status_i),
        .r0_resp_valid_o(r0_resp_valid_o), .r1_resp_valid_o(r1_resp_valid_o),
        .resp_rdata_o(resp_rdata_o), .resp_status_o(resp_status_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model state: queue of outstanding requester ids, in acceptance order.
    bit mq[$];
    bit m_prio, m_lock, m_hold, m_hgnt;
    int seq0 = 0, seq1 = 0;

    // Sampled DUT outputs from the most recent step, for literal checks.
    logic s_valid, s_r0rdy, s_r1rdy, s_err, s_one, s_r0resp, s_r1resp;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit model_gnt(input bit v0, input bit v1);
        if (m_lock) return 1'b0;
        if (m_hold) return m_hgnt;
        if (v0 && v1) return m_prio;
        return v1;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_prio = 0; m_lock = 0; m_hold = 0; m_hgnt = 0;
    endtask

    task automatic step(input bit v0, input bit l0, input bit v1, input bit tr,
                        input bit rv, input bit rst);
        bit g, full, gv, e_valid, acc, rsp, e_r0resp, e_r1resp, e_one;
        logic [68:0] e_fields;
        int nsz;
        rst_n = rst;
        r0_valid_i = v0; r0_lock_i = l0; r1_valid_i = v1;
        mpu_trans_ready_i = tr; mpu_resp_valid_i = rv;
        r0_addr_i = 32'h1000_0000 + 32'(seq0 * 4);
        r1_addr_i = 32'h2000_0000 + 32'(seq1 * 8);
        r0_we_i = 1'b1; r0_be_i = 4'hF; r0_wdata_i = 32'hA5A5_0000 + 32'(seq0);
        r1_we_i = 1'b0; r1_be_i = 4'h3; r1_wdata_i = 32'h5A5A_0000 + 32'(seq1);
        mpu_resp_rdata_i = $urandom;
        mpu_resp_status_i = 2'($urandom_range(0, 2));
        if (!rst) model_reset();
        #2;
        g        = rst ? model_gnt(v0, v1) : 1'b0;
        full     = (mq.size() == MAX);
        gv       = g ? v1 : v0;
        e_valid  = rst && gv && !full;
        acc      = e_valid && tr;
        rsp      = rst && rv && (mq.size() > 0);
        e_r0resp = rsp && (mq[0] == 1'b0);
        e_r1resp = rsp && (mq[0] == 1'b1);
        nsz      = mq.size() + int'(acc) - int'(rsp);
        e_one    = rst && (nsz == 1);
        e_fields = g ? {r1_addr_i, r1_we_i, r1_be_i, r1_wdata_i}
                     : {r0_addr_i, r0_we_i, r0_be_i, r0_wdata_i};

        chk("trans_valid", mpu_trans_valid_o, e_valid);
        chk("r0_ready", r0_ready_o, rst && tr && !g && !full);
        chk("r1_ready", r1_ready_o, rst && tr && g && !full);
        chk("err_wait", mpu_err_wait_o, !g);
        chk("mpu_fields", {mpu_addr_o, mpu_we_o, mpu_be_o, mpu_wdata_o}, e_fields);
        chk("r0_resp_valid", r0_resp_valid_o, e_r0resp);
        chk("r1_resp_valid", r1_resp_valid_o, e_r1resp);
        chk("resp_pass", {resp_rdata_o, resp_status_o}, {mpu_resp_rdata_i, mpu_resp_status_i});
        chk("one_txn_pend", one_txn_pend_n_o, e_one);

        s_valid = mpu_trans_valid_o; s_r0rdy = r0_ready_o; s_r1rdy = r1_ready_o;
        s_err = mpu_err_wait_o; s_one = one_txn_pend_n_o;
        s_r0resp = r0_resp_valid_o; s_r1resp = r1_resp_valid_o;

        @(posedge clk);
        if (rst) begin
            if (rsp) void'(mq.pop_front());
            if (acc) begin
                mq.push_back(g);
                m_prio = !g;
                if (!g) begin
                    m_lock = l0;
                    seq0++;
                end else begin
                    seq1++;
                end
            end
            m_hold = e_valid && !tr;
            m_hgnt = g;
        end
        #1;
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        r0_valid_i = 0; r0_lock_i = 0; r1_valid_i = 0;
        mpu_trans_ready_i = 0; mpu_resp_valid_i = 0;
        #3;

        // Reset: outputs quiet, err_wait high even with r1 requesting.
        step(0, 0, 1, 1, 1, 0);
        chk("lit_rst_err", s_err, 1'b1);
        chk("lit_rst_valid", s_valid, 1'b0);
        step(0, 0, 0, 0, 0, 1);

        // Both requesters every cycle, 1-cycle responses: strict alternation.
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 1, 1, i > 0, 1);
            chk("lit_alt_grant", s_err, (i % 2 == 0));
            if (i > 0) chk("lit_alt_route", {s_r0resp, s_r1resp}, (i % 2 == 1) ? 2'b10 : 2'b01);
        end
        step(0, 0, 0, 1, 1, 1);

        // Misaligned pair: both r0 halves before r1.
        step(1, 1, 1, 1, 0, 1);
        chk("lit_lock_first", s_err, 1'b1);
        step(1, 0, 1, 1, 1, 1);
        chk("lit_lock_second", s_err, 1'b1);
        step(0, 0, 1, 1, 1, 1);
        chk("lit_lock_then_r1", s_err, 1'b0);
        step(0, 0, 0, 1, 1, 1);

        // Full: no same-cycle bypass from a response.
        step(1, 0, 0, 1, 0, 1);
        step(1, 0, 1, 1, 0, 1);
        step(1, 0, 1, 1, 0, 1);
        chk("lit_full_valid", s_valid, 1'b0);
        chk("lit_full_ready", {s_r0rdy, s_r1rdy}, 2'b00);
        step(1, 0, 1, 1, 1, 1);
        chk("lit_full_resp_blocks", s_valid, 1'b0);
        chk("lit_full_resp_r0", s_r0resp, 1'b1);
        step(1, 0, 1, 1, 0, 1);
        chk("lit_full_after", s_valid, 1'b1);
        step(0, 0, 0, 1, 1, 1);
        step(0, 0, 0, 1, 1, 1);

        // one_txn_pend_n_o on 0->1 and 1->1 with simultaneous accept+response.
        step(1, 0, 0, 1, 0, 1);
        chk("lit_one_0to1", s_one, 1'b1);
        step(0, 0, 1, 1, 1, 1);
        chk("lit_one_1to1", s_one, 1'b1);
        step(0, 0, 0, 1, 1, 1);
        chk("lit_one_drain", s_one, 1'b0);

        // MPU stall: grant stays on r0 while r1 shows up.
        step(1, 0, 0, 0, 0, 1);
        step(1, 0, 1, 0, 0, 1);
        chk("lit_stall_hold", s_err, 1'b1);
        step(1, 0, 1, 0, 0, 1);
        step(1, 0, 1, 1, 0, 1);
        chk("lit_stall_accept", {s_err, s_r0rdy}, 2'b11);
        step(0, 0, 1, 1, 1, 1);
        step(0, 0, 0, 1, 1, 1);

        // Reset mid-flight with two outstanding, then a stray response.
        step(1, 0, 0, 1, 0, 1);
        step(0, 0, 1, 1, 0, 1);
        step(0, 0, 1, 1, 0, 0);
        chk("lit_midrst_err", s_err, 1'b1);
        step(0, 0, 0, 1, 1, 1);
        chk("lit_stray_resp", {s_r0resp, s_r1resp}, 2'b00);

        // Random traffic.
        for (int i = 0; i < 60; i++) begin
            step(1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom),
                 1'($urandom_range(0, 3) != 0), 1'($urandom), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
